fxp_divider: RTL

//  Multi-cycle signed fixed-point divider, the inverse of the ALU_MUL path.
//  - Operands and result are signed Q1.(N-1), the format ALU_MUL produces:

---
 rtl/fxp_divider_pkg.sv | 13 +
 rtl/fxp_divider_div_step.sv | 21 ++
 rtl/fxp_divider.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fxp_divider_pkg.sv
// Shared types and timing constants for the fixed-point divider.
package fxp_divider_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX} divState_t;

  localparam int DIV_N       = 8;
  localparam int DIV_LATENCY = 2 * DIV_N;

  function automatic int div_latency(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/fxp_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_rem,
  output logic         o_q
);

  logic [N:0] w_shift;
  logic [N:0] w_diff;

  assign w_shift = {i_rem[N-1:0], i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  // A set top remainder bit means the shifted value overflowed N+1 bits, so it always fits.
  assign o_q     = i_rem[N] | (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_q ? w_diff : w_shift;

endmodule

// File: rtl/fxp_divider.sv
// Multi-cycle signed Q1.(N-1) divider: restoring division on magnitudes, then sign fix and saturation.
//   state    | meaning
//   DIV_IDLE | waiting for start; result/flags held
//   DIV_CALC | one quotient bit per cycle, 2N-1 cycles
//   DIV_FIX  | apply sign, saturate, pulse done
module fxp_divider
  import fxp_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         dz
);

  localparam int            QW        = 2 * N - 1;
  localparam int            CW        = $clog2(div_latency(N));
  localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);
  localparam logic [QW-1:0] Q_MAX     = QW'((1 << (N - 1)) - 1);
  localparam logic [QW-1:0] Q_MIN_MAG = QW'(1 << (N - 1));
  localparam logic [N-1:0]  RES_MAX   = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0]  RES_MIN   = {1'b1, {(N - 1){1'b0}}};

  divState_t     r_state;
  logic          r_sign;
  logic          r_sign_a;
  logic          r_zero;
  logic [QW-1:0] r_dividend;
  logic [QW-1:0] r_quot;
  logic [N-1:0]  r_divisor;
  logic [N:0]    r_rem;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_result;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;
  logic          r_dz;

  logic [N-1:0]  w_abs_a;
  logic [N-1:0]  w_abs_b;
  logic [N:0]    w_step_rem;
  logic          w_step_q;
  divState_t     w_next_state;
  logic [N-1:0]  w_fix_result;
  logic          w_fix_ovf;

  // Magnitude of the most negative value wraps to 2^(N-1), which is correct as unsigned.
  assign w_abs_a = a[N-1] ? -a : a;
  assign w_abs_b = b[N-1] ? -b : b;

  div_step #(.N(N)) u_div_step (
    .i_rem     (r_rem),
    .i_bit     (r_dividend[QW-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_IDLE: if (start) w_next_state = DIV_CALC;
      DIV_CALC: if (r_cnt == LAST_ITER) w_next_state = DIV_FIX;
      DIV_FIX:  w_next_state = DIV_IDLE;
      default:  w_next_state = DIV_IDLE;
    endcase

    w_fix_result = r_sign ? -r_quot[N-1:0] : r_quot[N-1:0];
    w_fix_ovf    = 1'b0;
    if (r_zero) begin
      w_fix_result = r_sign_a ? RES_MIN : RES_MAX;
      w_fix_ovf    = 1'b1;
    end else if (!r_sign && (r_quot > Q_MAX)) begin
      w_fix_result = RES_MAX;
      w_fix_ovf    = 1'b1;
    end else if (r_sign && (r_quot > Q_MIN_MAG)) begin
      w_fix_result = RES_MIN;
      w_fix_ovf    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= DIV_IDLE;
      r_sign     <= 1'b0;
      r_sign_a   <= 1'b0;
      r_zero     <= 1'b0;
      r_dividend <= '0;
      r_quot     <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_dz       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_sign     <= a[N-1] ^ b[N-1];
            r_sign_a   <= a[N-1];
            r_zero     <= (b == '0);
            r_dividend <= {w_abs_a, {(N - 1){1'b0}}};
            r_divisor  <= w_abs_b;
            r_quot     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
          end
        end
        DIV_CALC: begin
          r_rem      <= w_step_rem;
          r_quot     <= {r_quot[QW-2:0], w_step_q};
          r_dividend <= {r_dividend[QW-2:0], 1'b0};
          r_cnt      <= r_cnt + 1'b1;
        end
        DIV_FIX: begin
          r_result <= w_fix_result;
          r_ovf    <= w_fix_ovf;
          r_dz     <= r_zero;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
  assign ovf    = r_ovf;
  assign dz     = r_dz;

endmodule
